// File: rtl/ndp_operand_loader.sv
// Operand loader for the NDP compute unit: gathers A (4 words) and B (4 x B_BEATS words) from a beat stream.
// Optional macro NDP_LOADER_ZEROFILL_EN: an early s_last on a B beat ends the load and zeroes the remaining lanes.
module ndp_operand_loader #(
    parameter int WIDTH   = 16,
    parameter int B_BEATS = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_simd,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [4*WIDTH-1:0]           s_data,
    input  logic                         s_last,
    output logic [4*WIDTH-1:0]           in_a,
    output logic [4*B_BEATS*WIDTH-1:0]   in_b,
    output logic                         in_done_flag,
    output logic [1:0]                   simd_control,
    input  logic                         calc_done_flag,
    output logic                         busy,
    output logic                         err_last
);
    localparam int BEAT_W = 4 * WIDTH;
    localparam int CNT_W  = (B_BEATS > 1) ? $clog2(B_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(B_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        DONE,
        WAIT_CALC
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [BEAT_W-1:0]            in_a_q, in_a_d;
    logic [4*B_BEATS*WIDTH-1:0]   in_b_q, in_b_d;
    logic [1:0]                   simd_q, simd_d;
    logic                         err_q, err_d;

    logic cmd_acc;
    logic a_beat;
    logic b_beat;
    logic b_final;
    logic b_early_end;

    assign cmd_acc = (state_q == IDLE) && cmd_valid;
    assign a_beat  = (state_q == LOAD_A) && s_valid;
    assign b_beat  = (state_q == LOAD_B) && s_valid;
    assign b_final = b_beat && (cnt_q == LAST_BEAT);

`ifdef NDP_LOADER_ZEROFILL_EN
    assign b_early_end = b_beat && s_last && (cnt_q != LAST_BEAT);
`else
    assign b_early_end = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (cmd_valid) state_d = LOAD_A;
            LOAD_A:    if (s_valid) state_d = LOAD_B;
            LOAD_B:    if (b_final || b_early_end) state_d = DONE;
            DONE:      state_d = calc_done_flag ? IDLE : WAIT_CALC;
            WAIT_CALC: if (calc_done_flag) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready    = 1'b0;
        s_ready      = 1'b0;
        in_done_flag = 1'b0;
        busy         = (state_q != IDLE);
        unique case (state_q)
            IDLE:      cmd_ready = 1'b1;
            LOAD_A:    s_ready = 1'b1;
            LOAD_B:    s_ready = 1'b1;
            DONE:      in_done_flag = 1'b1;
            WAIT_CALC: ;
            default:   ;
        endcase
    end

    // Operands move only on accepted commands or beats; they hold through DONE, WAIT_CALC and IDLE.
    always_comb begin
        cnt_d  = cnt_q;
        in_a_d = in_a_q;
        in_b_d = in_b_q;
        simd_d = simd_q;
        err_d  = err_q;

        if (cmd_acc) begin
            simd_d = cmd_simd;
            err_d  = 1'b0;
            cnt_d  = '0;
        end

        if (a_beat) begin
            in_a_d = s_data;
            if (s_last) err_d = 1'b1;
        end

        if (b_beat) begin
            for (int k = 0; k < B_BEATS; k++) begin
                if (k == int'(cnt_q)) begin
                    in_b_d[k*BEAT_W +: BEAT_W] = s_data;
                end else if (b_early_end && (k > int'(cnt_q))) begin
                    in_b_d[k*BEAT_W +: BEAT_W] = '0;
                end
            end
            if (cnt_q != LAST_BEAT) cnt_d = cnt_q + 1'b1;
            if (b_final) begin
                if (!s_last) err_d = 1'b1;
            end else if (s_last && !b_early_end) begin
                err_d = 1'b1;
            end
        end
    end

    // NOTE: the wide operand registers are reset too, since reset must present all-zero operands.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            in_a_q <= '0;
            in_b_q <= '0;
            simd_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            in_a_q <= in_a_d;
            in_b_q <= in_b_d;
            simd_q <= simd_d;
            err_q  <= err_d;
        end
    end

    assign in_a         = in_a_q;
    assign in_b         = in_b_q;
    assign simd_control = simd_q;
    assign err_last     = err_q;

endmodule

// File: tb/tb_ndp_operand_loader.sv
// Self-checking bench for ndp_operand_loader: job table, reset-mid-load sequence and randomized jobs vs a job-level model.
module tb_ndp_operand_loader;
    localparam int WIDTH   = 16;
    localparam int B_BEATS = 64;
    localparam int BW      = 4 * WIDTH;
    localparam int NB      = B_BEATS + 1;

    logic                  clk;
    logic                  reset;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_simd;
    logic                  s_valid;
    logic                  s_ready;
    logic [BW-1:0]         s_data;
    logic                  s_last;
    logic [BW-1:0]         in_a;
    logic [B_BEATS*BW-1:0] in_b;
    logic                  in_done_flag;
    logic [1:0]            simd_control;
    logic                  calc_done_flag;
    logic                  busy;
    logic                  err_last;

    // anomaly: 0 none, 1 s_last forced on beat anom_pos (0 = A beat), 2 s_last dropped on the final beat
    typedef struct {
        logic [1:0] simd;
        bit         rnd_data;
        int         anomaly;
        int         anom_pos;
        bit         stall;
        int         hold;
        bit         calc_early;
        bit         chk_tab;
        bit         exp_err;
    } vec_t;

    int checks      = 0;
    int errors      = 0;
    int done_pulses = 0;
    int beats_seen  = 0;
    bit abort       = 1'b0;

    logic [BW-1:0] bd [NB];
    bit            bl [NB];
    logic [BW-1:0] exp_a;
    logic [BW-1:0] exp_b [B_BEATS];
    bit            exp_err;
    int            exp_n;

    vec_t tab [6];

    ndp_operand_loader #(.WIDTH(WIDTH), .B_BEATS(B_BEATS)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_simd       (cmd_simd),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_done_flag   (in_done_flag),
        .simd_control   (simd_control),
        .calc_done_flag (calc_done_flag),
        .busy           (busy),
        .err_last       (err_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (in_done_flag === 1'b1) done_pulses++;
        if (reset === 1'b1 && s_valid === 1'b1 && s_ready === 1'b1) beats_seen++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_job(input vec_t v);
        for (int i = 0; i < NB; i++) begin
            if (v.rnd_data) bd[i] = {$urandom, $urandom};
            else if (i == 0) bd[i] = 64'h0004_0003_0002_0001;
            else bd[i] = {4{16'(i - 1)}};
            bl[i] = (i == NB - 1);
        end
        if (v.anomaly == 1) bl[v.anom_pos] = 1'b1;
        if (v.anomaly == 2) bl[NB-1] = 1'b0;
    endtask

    // Job-level model: beat 0 is A, beat k+1 is B lane k; unwritten lanes stay zero.
    task automatic model_job();
        exp_a   = bd[0];
        exp_err = bl[0];
        exp_n   = NB;
        for (int k = 0; k < B_BEATS; k++) exp_b[k] = '0;
        for (int k = 0; k < B_BEATS; k++) begin
            exp_b[k] = bd[k+1];
            if (k == B_BEATS - 1) begin
                if (!bl[k+1]) exp_err = 1'b1;
            end else if (bl[k+1]) begin
`ifdef NDP_LOADER_ZEROFILL_EN
                exp_n = k + 2;
                break;
`else
                exp_err = 1'b1;
`endif
            end
        end
    endtask

    task automatic send_cmd(input string tag, input logic [1:0] simd);
        int b0;
        bit hs;
        b0        = beats_seen;
        hs        = 1'b0;
        cmd_valid = 1'b1;
        cmd_simd  = simd;
        s_valid   = 1'b1;
        s_data    = 64'hDEAD_BEEF_DEAD_BEEF;
        s_last    = 1'b0;
        for (int t = 0; t < 50; t++) begin
            hs = cmd_ready;
            step();
            if (hs) break;
        end
        cmd_valid = 1'b0;
        s_valid   = 1'b0;
        if (!hs) begin
            check({tag, "_cmd_timeout"}, 64'd0, 64'd1);
            abort = 1'b1;
        end
        check({tag, "_idle_beat_rejected"}, 64'(beats_seen - b0), 64'd0);
    endtask

    task automatic send_beats(input string tag, input int first, input int count, input bit stall);
        int idx;
        int t;
        bit hs;
        idx = first;
        t   = 0;
        while (idx < first + count && t < 4000) begin
            s_valid = !stall || ($urandom_range(0, 1) != 0);
            s_data  = bd[idx];
            s_last  = bl[idx];
            hs      = s_valid && s_ready;
            step();
            t++;
            if (hs) idx++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (idx < first + count) begin
            check({tag, "_beat_timeout"}, 64'(idx), 64'(first + count));
            abort = 1'b1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_a"}, in_a, 64'd0);
        check({tag, "_in_b_any"}, 64'(|in_b), 64'd0);
        check({tag, "_simd"}, 64'(simd_control), 64'd0);
        check({tag, "_done"}, 64'(in_done_flag), 64'd0);
        check({tag, "_err"}, 64'(err_last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int p0;
        int b0;
        int bad;
        gen_job(v);
        model_job();
        calc_done_flag = v.calc_early;
        send_cmd(tag, v.simd);
        if (abort) return;
        check({tag, "_simd"}, 64'(simd_control), 64'(v.simd));
        check({tag, "_err_cleared"}, 64'(err_last), 64'd0);
        check({tag, "_load_a_s_ready"}, 64'(s_ready), 64'd1);
        check({tag, "_load_busy"}, 64'(busy), 64'd1);
        p0 = done_pulses;
        b0 = beats_seen;
        send_beats(tag, 0, exp_n, v.stall);
        if (abort) return;
        check({tag, "_done_flag"}, 64'(in_done_flag), 64'd1);
        check({tag, "_done_s_ready"}, 64'(s_ready), 64'd0);
        check({tag, "_done_cmd_ready"}, 64'(cmd_ready), 64'd0);
        if (v.calc_early) begin
            step();
            calc_done_flag = 1'b0;
        end else begin
            bad = 0;
            for (int c = 0; c < v.hold; c++) begin
                s_valid   = 1'b1;
                s_data    = {$urandom, $urandom};
                cmd_valid = 1'b1;
                step();
                if (s_ready !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1 || in_done_flag !== 1'b0) bad++;
            end
            s_valid   = 1'b0;
            cmd_valid = 1'b0;
            check({tag, "_hold_violations"}, 64'(bad), 64'd0);
            calc_done_flag = 1'b1;
            step();
            calc_done_flag = 1'b0;
        end
        check({tag, "_idle_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_done_pulses"}, 64'(done_pulses - p0), 64'd1);
        check({tag, "_beats"}, 64'(beats_seen - b0), 64'(exp_n));
        check({tag, "_in_a"}, in_a, exp_a);
        check({tag, "_err"}, 64'(err_last), 64'(exp_err));
        if (v.chk_tab) check({tag, "_err_tab"}, 64'(err_last), 64'(v.exp_err));
        for (int k = 0; k < B_BEATS; k++)
            check($sformatf("%s_b%0d", tag, k), in_b[k*BW +: BW], exp_b[k]);
    endtask

    initial begin
        vec_t r;

        //         simd   rnd   anom pos stall hold early tab  err
        tab[0] = '{2'd2, 1'b0, 0,   0,  1'b0, 20,  1'b0, 1'b1, 1'b0};
        tab[1] = '{2'd2, 1'b0, 0,   0,  1'b1, 2,   1'b0, 1'b1, 1'b0};
        tab[2] = '{2'd1, 1'b1, 1,   0,  1'b0, 1,   1'b0, 1'b1, 1'b1};
        tab[3] = '{2'd3, 1'b1, 2,   0,  1'b1, 1,   1'b0, 1'b1, 1'b1};
`ifdef NDP_LOADER_ZEROFILL_EN
        tab[4] = '{2'd0, 1'b1, 1,   10, 1'b0, 3,   1'b0, 1'b1, 1'b0};
`else
        tab[4] = '{2'd0, 1'b1, 1,   11, 1'b0, 3,   1'b0, 1'b1, 1'b1};
`endif
        tab[5] = '{2'd2, 1'b1, 0,   0,  1'b1, 0,   1'b1, 1'b1, 1'b0};

        reset          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_simd       = 2'd0;
        s_valid        = 1'b0;
        s_data         = '0;
        s_last         = 1'b0;
        calc_done_flag = 1'b0;
        repeat (3) step();
        check_reset_state("por");
        reset = 1'b1;
        step();

        for (int i = 0; i < 6 && !abort; i++)
            run_vec(tab[i], $sformatf("tab%0d", i));

        if (!abort) begin
            r = '{2'd3, 1'b1, 1, 0, 1'b1, 1, 1'b0, 1'b0, 1'b0};
            gen_job(r);
            send_cmd("rst", 2'd3);
            if (!abort) send_beats("rst", 0, 32, 1'b1);
            if (!abort) begin
                check("rst_err_before", 64'(err_last), 64'd1);
                reset = 1'b0;
                step();
                check_reset_state("rst");
                reset = 1'b1;
                step();
                run_vec(tab[0], "post_rst");
            end
        end

        for (int n = 0; n < 6 && !abort; n++) begin
            int a;
            r.simd       = 2'($urandom_range(0, 3));
            r.rnd_data   = 1'b1;
            a            = int'($urandom_range(0, 9));
            r.anomaly    = (a < 6) ? 0 : (a < 8) ? 1 : 2;
            r.anom_pos   = int'($urandom_range(0, NB - 1));
            r.stall      = ($urandom_range(0, 1) != 0);
            r.hold       = int'($urandom_range(1, 4));
            r.calc_early = ($urandom_range(0, 1) != 0);
            r.chk_tab    = 1'b0;
            r.exp_err    = 1'b0;
            run_vec(r, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
